// File: rtl/gpu_wb_pkg.sv
// Shared types and helpers for the GPU pixel writeback stage.
package gpu_wb_pkg;

    localparam int unsigned LINE_PIX = 8;
    localparam int unsigned ADR_W    = 16;

    typedef enum logic [1:0] {
        StEmpty,
        StAccum,
        StFlush
    } wbState_e;

    // Line address: one tag per group of eight horizontally adjacent pixels.
    function automatic logic [ADR_W-1:0] lineTag(input logic [8:0] scrY, input logic [6:0] lineX);
        return {scrY, lineX};
    endfunction

    // 5-bit texel channel times 8-bit vertex channel, 128 = unity, saturating at 31.
    function automatic logic [4:0] modChannel(input logic [4:0] t5, input logic [7:0] c8);
        logic [12:0] prod;
        prod = {8'd0, t5} * {5'd0, c8};
        if (prod >= 13'd4096) begin
            return 5'd31;
        end
        return 5'(prod >> 7);
    endfunction

endpackage

// File: rtl/gpu_pix_modulate.sv
// Combinational texel x vertex-colour modulation for the three 5-bit channels.
module gpu_pix_modulate
    import gpu_wb_pkg::*;
(
    input  logic [14:0] texel,
    input  logic        textured,
    input  logic [7:0]  colR,
    input  logic [7:0]  colG,
    input  logic [7:0]  colB,
    output logic [14:0] color
);

    always_comb begin
        if (textured) begin
            color = {modChannel(texel[14:10], colB),
                     modChannel(texel[9:5],   colG),
                     modChannel(texel[4:0],   colR)};
        end else begin
            color = {colB[7:3], colG[7:3], colR[7:3]};
        end
    end

endmodule

// File: rtl/gpu_pixel_writeback.sv
// Packs shaded pixels into an 8-pixel VRAM line buffer and flushes it to the write arbiter.
module gpu_pixel_writeback
    import gpu_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_validPixel,
    input  logic [1:0]            i_newBGCacheLine,
    input  logic [9:0]            i_scrX,
    input  logic [8:0]            i_scrY,
    input  logic [15:0]           i_texel,
    input  logic                  i_transparent,
    input  logic                  i_textured,
    input  logic [8:0]            i_R,
    input  logic [8:0]            i_G,
    input  logic [8:0]            i_B,
    input  logic                  i_setMaskBit,
    input  logic                  i_upStall,
    input  logic                  i_flush,
    output logic                  o_pause,
    output logic                  o_resetLineFlag,
    output logic                  o_wrReq,
    output logic [ADR_W-1:0]      o_wrAdr,
    output logic [LINE_PIX*16-1:0] o_wrData,
    output logic [LINE_PIX-1:0]   o_wrMask,
    input  logic                  i_wrAck,
    output logic                  o_idle
);

    wbState_e                stateQ, stateD;
    logic [ADR_W-1:0]        tagQ, tagD;
    logic [LINE_PIX*16-1:0]  dataQ, dataD;
    logic [LINE_PIX-1:0]     maskQ, maskD;

    logic             offer;
    logic             newLine;
    logic [ADR_W-1:0] pixTag;
    logic [2:0]       slot;
    logic             conflict;
    logic             consume;
    logic             writePix;
    logic [14:0]      modColor;
    logic [15:0]      pixWord;
    logic             unusedColorMsb;

    assign unusedColorMsb = i_R[8] ^ i_G[8] ^ i_B[8];

    gpu_pix_modulate uModulate (
        .texel    (i_texel[14:0]),
        .textured (i_textured),
        .colR     (i_R[7:0]),
        .colG     (i_G[7:0]),
        .colB     (i_B[7:0]),
        .color    (modColor)
    );

    assign offer    = i_validPixel & ~i_upStall;
    assign newLine  = |i_newBGCacheLine;
    assign pixTag   = lineTag(i_scrY, i_scrX[9:3]);
    assign slot     = i_scrX[2:0];
    assign pixWord  = {(i_texel[15] & i_textured) | i_setMaskBit, modColor};
    // Built from i_validPixel rather than offer so i_upStall never reaches o_pause.
    assign conflict = i_validPixel & ~i_transparent & ((pixTag != tagQ) | newLine);

    always_comb begin
        stateD   = stateQ;
        tagD     = tagQ;
        dataD    = dataQ;
        maskD    = maskQ;
        o_pause  = 1'b0;
        consume  = 1'b0;
        writePix = 1'b0;

        unique case (stateQ)
            StEmpty: begin
                if (offer) begin
                    consume = 1'b1;
                    if (!i_transparent) begin
                        tagD     = pixTag;
                        maskD    = '0;
                        writePix = 1'b1;
                        stateD   = i_flush ? StFlush : StAccum;
                    end
                end
            end
            StAccum: begin
                if (conflict) begin
                    o_pause = 1'b1;
                    stateD  = StFlush;
                end else begin
                    if (offer) begin
                        consume  = 1'b1;
                        writePix = ~i_transparent;
                    end
                    if (i_flush) begin
                        stateD = StFlush;
                    end
                end
            end
            StFlush: begin
                o_pause = 1'b1;
                if (i_wrAck) begin
                    maskD  = '0;
                    stateD = StEmpty;
                end
            end
            default: stateD = StEmpty;
        endcase

        if (writePix) begin
            maskD[slot]             = 1'b1;
            dataD[{slot, 4'd0} +: 16] = pixWord;
        end
    end

    assign o_resetLineFlag = consume & newLine;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            stateQ <= StEmpty;
            tagQ   <= '0;
            dataQ  <= '0;
            maskQ  <= '0;
        end else begin
            stateQ <= stateD;
            tagQ   <= tagD;
            dataQ  <= dataD;
            maskQ  <= maskD;
        end
    end

    assign o_wrReq  = (stateQ == StFlush);
    assign o_wrAdr  = tagQ;
    assign o_wrData = dataQ;
    assign o_wrMask = maskQ;
    assign o_idle   = (stateQ == StEmpty);

endmodule

// File: tb/tb_gpu_pixel_writeback.sv
// Directed self-checking bench for gpu_pixel_writeback.
module tb_gpu_pixel_writeback;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_validPixel;
    logic [1:0]   i_newBGCacheLine;
    logic [9:0]   i_scrX;
    logic [8:0]   i_scrY;
    logic [15:0]  i_texel;
    logic         i_transparent;
    logic         i_textured;
    logic [8:0]   i_R, i_G, i_B;
    logic         i_setMaskBit;
    logic         i_upStall;
    logic         i_flush;
    logic         o_pause;
    logic         o_resetLineFlag;
    logic         o_wrReq;
    logic [15:0]  o_wrAdr;
    logic [127:0] o_wrData;
    logic [7:0]   o_wrMask;
    logic         i_wrAck;
    logic         o_idle;

    int numChecks = 0;
    int numPass   = 0;

    gpu_pixel_writeback dut (
        .clk              (clk),
        .i_rst            (i_rst),
        .i_validPixel     (i_validPixel),
        .i_newBGCacheLine (i_newBGCacheLine),
        .i_scrX           (i_scrX),
        .i_scrY           (i_scrY),
        .i_texel          (i_texel),
        .i_transparent    (i_transparent),
        .i_textured       (i_textured),
        .i_R              (i_R),
        .i_G              (i_G),
        .i_B              (i_B),
        .i_setMaskBit     (i_setMaskBit),
        .i_upStall        (i_upStall),
        .i_flush          (i_flush),
        .o_pause          (o_pause),
        .o_resetLineFlag  (o_resetLineFlag),
        .o_wrReq          (o_wrReq),
        .o_wrAdr          (o_wrAdr),
        .o_wrData         (o_wrData),
        .o_wrMask         (o_wrMask),
        .i_wrAck          (i_wrAck),
        .o_idle           (o_idle)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        numChecks++;
        if (got === exp) begin
            numPass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] x, input logic [8:0] y, input logic [15:0] tex,
                       input logic transp, input logic textured,
                       input logic [8:0] r, input logic [8:0] g, input logic [8:0] b,
                       input logic [1:0] nl);
        i_validPixel     = 1'b1;
        i_scrX           = x;
        i_scrY           = y;
        i_texel          = tex;
        i_transparent    = transp;
        i_textured       = textured;
        i_R              = r;
        i_G              = g;
        i_B              = b;
        i_newBGCacheLine = nl;
        #1;
    endtask

    task automatic flushLine();
        i_validPixel = 1'b0;
        i_flush      = 1'b1;
        step();
        i_flush      = 1'b0;
        #1;
    endtask

    task automatic ackLine();
        i_wrAck = 1'b1;
        step();
        i_wrAck = 1'b0;
        #1;
    endtask

    logic [15:0] expSlot [6];

    initial begin
        i_rst = 1'b1;
        i_validPixel = 1'b0; i_newBGCacheLine = 2'd0; i_scrX = '0; i_scrY = '0;
        i_texel = '0; i_transparent = 1'b0; i_textured = 1'b0;
        i_R = '0; i_G = '0; i_B = '0; i_setMaskBit = 1'b0; i_upStall = 1'b0;
        i_flush = 1'b0; i_wrAck = 1'b0;
        step();
        step();
        checkVal("rst_wrReq", o_wrReq, 0);
        checkVal("rst_pause", o_pause, 0);
        checkVal("rst_flag", o_resetLineFlag, 0);
        checkVal("rst_idle", o_idle, 1);
        checkVal("rst_mask", o_wrMask, 0);
        checkVal("rst_adr", o_wrAdr, 0);
        checkVal("rst_data", o_wrData, 0);
        i_rst = 1'b0;
        step();

        // 1: full untextured line at Y=5
        for (int x = 0; x < 8; x++) begin
            pix(10'(x), 9'd5, 16'h0000, 1'b0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, (x == 0) ? 2'd1 : 2'd0);
            checkVal("t1_flag", o_resetLineFlag, (x == 0) ? 1 : 0);
            checkVal("t1_pause", o_pause, 0);
            step();
        end
        checkVal("t1_idle_accum", o_idle, 0);
        flushLine();
        checkVal("t1_wrReq", o_wrReq, 1);
        checkVal("t1_adr", o_wrAdr, 16'h0280);
        checkVal("t1_mask", o_wrMask, 8'hFF);
        checkVal("t1_data", o_wrData, {8{16'h7FFF}});
        ackLine();
        checkVal("t1_idle", o_idle, 1);
        checkVal("t1_wrReq_done", o_wrReq, 0);

        // 2: modulation and mask bit
        pix(10'd0, 9'd10, 16'h001F, 1'b0, 1'b1, 9'h080, 9'h000, 9'h000, 2'd1); step();
        pix(10'd1, 9'd10, 16'h001F, 1'b0, 1'b1, 9'h040, 9'h000, 9'h000, 2'd0); step();
        pix(10'd2, 9'd10, 16'h001F, 1'b0, 1'b1, 9'h0FF, 9'h000, 9'h000, 2'd0); step();
        pix(10'd3, 9'd10, 16'h801F, 1'b0, 1'b1, 9'h080, 9'h000, 9'h000, 2'd0); step();
        i_setMaskBit = 1'b1;
        pix(10'd4, 9'd10, 16'h0000, 1'b0, 1'b0, 9'h010, 9'h010, 9'h010, 2'd0); step();
        i_setMaskBit = 1'b0;
        pix(10'd5, 9'd10, 16'h2A80, 1'b0, 1'b1, 9'h080, 9'h040, 9'h0C0, 2'd0); step();
        flushLine();
        expSlot[0] = 16'h001F; expSlot[1] = 16'h000F; expSlot[2] = 16'h001F;
        expSlot[3] = 16'h801F; expSlot[4] = 16'h8842; expSlot[5] = 16'h3D40;
        checkVal("t2_adr", o_wrAdr, 16'h0500);
        checkVal("t2_mask", o_wrMask, 8'h3F);
        for (int s = 0; s < 6; s++) begin
            checkVal($sformatf("t2_slot%0d", s), o_wrData[s*16 +: 16], expSlot[s]);
        end
        ackLine();

        // 3: line crossing forces a flush and replays the pending pixel
        pix(10'd6, 9'd20, 16'h0000, 1'b0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 2'd1); step();
        pix(10'd7, 9'd20, 16'h0000, 1'b0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 2'd0); step();
        pix(10'd8, 9'd20, 16'h0000, 1'b0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 2'd0);
        checkVal("t3_pause_same", o_pause, 1);
        checkVal("t3_wrReq_not_yet", o_wrReq, 0);
        step();
        checkVal("t3_wrReq", o_wrReq, 1);
        checkVal("t3_adr", o_wrAdr, 16'h0A00);
        checkVal("t3_mask", o_wrMask, 8'hC0);
        i_wrAck = 1'b1;
        #1;
        checkVal("t3_pause_ack", o_pause, 1);
        step();
        i_wrAck = 1'b0;
        #1;
        checkVal("t3_pause_after", o_pause, 0);
        checkVal("t3_wrReq_after", o_wrReq, 0);
        step();
        flushLine();
        checkVal("t3_adr2", o_wrAdr, 16'h0A01);
        checkVal("t3_mask2", o_wrMask, 8'h01);
        checkVal("t3_data2", o_wrData[15:0], 16'h7FFF);
        ackLine();

        // 4: transparent texel leaves a hole
        pix(10'd2, 9'd30, 16'h0000, 1'b0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 2'd1);
        checkVal("t4_pause_a", o_pause, 0); step();
        pix(10'd3, 9'd30, 16'h0000, 1'b1, 1'b1, 9'h0FF, 9'h0FF, 9'h0FF, 2'd0);
        checkVal("t4_pause_b", o_pause, 0); step();
        pix(10'd4, 9'd30, 16'h0000, 1'b0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 2'd0);
        checkVal("t4_pause_c", o_pause, 0); step();
        flushLine();
        checkVal("t4_adr", o_wrAdr, 16'h0F00);
        checkVal("t4_mask", o_wrMask, 8'h14);
        ackLine();

        // 5: upstream stall blocks consumption; slow ack keeps request stable
        pix(10'd0, 9'd40, 16'h0000, 1'b0, 1'b0, 9'h080, 9'h080, 9'h080, 2'd1); step();
        i_upStall = 1'b1;
        pix(10'd1, 9'd40, 16'h0000, 1'b0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 2'd0);
        checkVal("t5_flag_stall", o_resetLineFlag, 0);
        step(); step();
        i_upStall = 1'b0;
        flushLine();
        for (int c = 0; c < 10; c++) begin
            checkVal("t5_wrReq", o_wrReq, 1);
            checkVal("t5_adr", o_wrAdr, 16'h1400);
            checkVal("t5_data", o_wrData[15:0], 16'h4210);
            checkVal("t5_pause", o_pause, 1);
            step();
        end
        checkVal("t5_mask", o_wrMask, 8'h01);
        ackLine();

        // 6: reset while flushing
        pix(10'd0, 9'd50, 16'h0000, 1'b0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 2'd1); step();
        flushLine();
        checkVal("t6_wrReq_pre", o_wrReq, 1);
        #1;
        i_rst = 1'b1;
        #1;
        checkVal("t6_wrReq_rst", o_wrReq, 0);
        checkVal("t6_idle_rst", o_idle, 1);
        checkVal("t6_mask_rst", o_wrMask, 0);
        step();
        i_rst = 1'b0;
        step();
        flushLine();
        checkVal("t6_no_write", o_wrReq, 0);
        step();
        checkVal("t6_idle", o_idle, 1);

        $display("%0d/%0d checks passed", numPass, numChecks);
        $finish;
    end

endmodule
